// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared constants, types and helpers for the FIR sample-feeder stage.
//   NUM_TAPS  taps per output; equals the MAC frame length
//   DATA_W    sample / coefficient width
//   ADDR_W    tap RAM byte-address width
//   TAP_BASE  byte address of h[0]; h[k] lives at TAP_BASE + 4*k
//   PHASE_W   width of the frame phase counter
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int unsigned NUM_TAPS = 11;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 12;
  localparam logic [ADDR_W-1:0] TAP_BASE = 12'h000;
  localparam int unsigned PHASE_W  = $clog2(NUM_TAPS);

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t LAST_PHASE = phase_t'(NUM_TAPS - 1);

  // Tag carried alongside a frame: does it hold a real sample, and is that
  // sample the last of its block.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Byte address of coefficient h[k].
  function automatic logic [ADDR_W-1:0] tap_addr(input phase_t k);
    return TAP_BASE + {{(ADDR_W - PHASE_W - 2){1'b0}}, k, 2'b00};
  endfunction

  // Frame phase successor, wrapping LAST_PHASE -> 0.
  function automatic phase_t phase_inc(input phase_t p);
    return (p == LAST_PHASE) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fir_sample_shiftbuf.sv
// -----------------------------------------------------------------------------
// fir_sample_shiftbuf
//   DEPTH x WIDTH sample history. Entry 0 is the newest sample, entry k is
//   the sample k accepts older.
//   CLK       clock
//   Resetn    asynchronous active-low reset, clears all entries
//   shift_en  shift history by one and load din into entry 0
//   clr       synchronous clear; entry 0 still loads din when shifting
//   din       new sample
//   rd_idx    read index
//   dout      entry rd_idx (combinational), 0 for an out-of-range index
// -----------------------------------------------------------------------------
module fir_sample_shiftbuf
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = NUM_TAPS,
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Resetn,
  input  logic             shift_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= clr ? '0 : mem[i-1];
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end
  end

  always_comb begin
    dout = '0;
    if (32'(rd_idx) < DEPTH) dout = mem[rd_idx];
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// -----------------------------------------------------------------------------
// fir_sample_feeder
//   Upstream stage of the 11-cycle FIR MAC. Accepts samples on an AXI-Stream
//   slave, keeps the last NUM_TAPS samples, and drives one {X, tap} term per
//   cycle in lock-step with the MAC's free-running frame. Coefficients are
//   prefetched from the tap RAM one cycle ahead. y_valid/y_last mark the
//   cycle in which the MAC presents a finished sum for a real sample.
//   CLK        clock
//   Resetn     asynchronous active-low reset
//   en         level enable; 0 blocks sample acceptance
//   clr        synchronous clear of the sample history
//   ss_tvalid  AXI-S sample valid
//   ss_tdata   sample x[n]
//   ss_tlast   last sample of block
//   ss_tready  AXI-S ready (only during the last phase of a frame)
//   tap_EN     tap RAM read enable
//   tap_A      tap RAM byte address
//   tap_Do     tap RAM read data, one cycle after tap_A/tap_EN
//   X          sample operand to MAC
//   tap        coefficient operand to MAC (tap_Do passthrough)
//   y_valid    MAC output this cycle belongs to a real sample
//   y_last     that sample carried tlast
// -----------------------------------------------------------------------------
module fir_sample_feeder
  import fir_pkg::*;
(
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              en,
  input  logic              clr,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              tap_EN,
  output logic [ADDR_W-1:0] tap_A,
  input  logic [DATA_W-1:0] tap_Do,
  output logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] tap,
  output logic              y_valid,
  output logic              y_last
);

  phase_t            phase;
  phase_t            phase_nxt;
  tag_t              cur_tag;
  logic              frame_end;
  logic              accept;
  logic [DATA_W-1:0] buf_dout;

  // The phase counter never stalls: the MAC runs its own frame and has no
  // restart other than reset, so every frame boundary here must match it.
  assign frame_end = (phase == LAST_PHASE);
  assign accept    = frame_end && ss_tvalid && ss_tready;
  assign phase_nxt = phase_inc(phase);

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      phase     <= '0;
      cur_tag   <= '0;
      ss_tready <= 1'b0;
      tap_EN    <= 1'b0;
      tap_A     <= TAP_BASE;
      y_valid   <= 1'b0;
      y_last    <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      // Ready is only offered in the slot where a sample can be loaded.
      ss_tready <= en && (phase_nxt == LAST_PHASE);
      // Address the coefficient for the phase after the one being entered,
      // so tap_Do carries h[k] exactly during phase k.
      tap_EN    <= 1'b1;
      tap_A     <= tap_addr(phase_inc(phase_nxt));
      if (frame_end) begin
        // The frame now ending was computed from cur_tag's sample; its sum
        // appears at the MAC in the next cycle.
        y_valid       <= cur_tag.valid;
        y_last        <= cur_tag.last;
        cur_tag.valid <= accept;
        cur_tag.last  <= accept && ss_tlast;
      end else begin
        y_valid <= 1'b0;
        y_last  <= 1'b0;
      end
    end
  end

  fir_sample_shiftbuf #(
    .DEPTH (NUM_TAPS),
    .WIDTH (DATA_W)
  ) u_shiftbuf (
    .CLK      (CLK),
    .Resetn   (Resetn),
    .shift_en (accept),
    .clr      (clr),
    .din      (ss_tdata),
    .rd_idx   (phase),
    .dout     (buf_dout)
  );

  // A frame without a fresh sample contributes nothing to the MAC.
  always_comb begin
    X = '0;
    if (cur_tag.valid) X = buf_dout;
  end

  assign tap = tap_Do;

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;
  import fir_pkg::*;

  localparam int NT = 11;

  logic        CLK       = 1'b0;
  logic        Resetn    = 1'b0;
  logic        en        = 1'b0;
  logic        clr       = 1'b0;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata  = '0;
  logic        ss_tlast  = 1'b0;
  logic [31:0] tap_Do    = '0;
  logic        ss_tready;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic [31:0] X;
  logic [31:0] tap;
  logic        y_valid;
  logic        y_last;

  int checks = 0;
  int errors = 0;

  fir_sample_feeder dut (
    .CLK       (CLK),
    .Resetn    (Resetn),
    .en        (en),
    .clr       (clr),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .tap_EN    (tap_EN),
    .tap_A     (tap_A),
    .tap_Do    (tap_Do),
    .X         (X),
    .tap       (tap),
    .y_valid   (y_valid),
    .y_last    (y_last)
  );

  always #5 CLK = ~CLK;

  // Tap RAM: h[k] = k+1 at byte address 4*k, one-cycle read latency.
  always @(posedge CLK)
    if (tap_EN) tap_Do <= (tap_A[11:2] < 10'd11) ? 32'(tap_A[11:2]) + 32'd1 : 32'd0;

  // Reference model state (spec-level view of the feeder)
  int          m_phase;
  int          m_since;
  logic [31:0] m_hist [NT];
  bit          m_valid, m_last, m_tready, m_yvalid, m_ylast;
  logic [31:0] exp_acc, exp_y;
  logic [31:0] mac_acc, mac_y;
  int          exp_ycnt;
  logic [31:0] obs_y [$];
  bit          obs_l [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_y(input int i);
    return (i < obs_y.size()) ? obs_y[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] get_l(input int i);
    return (i < obs_l.size()) ? 32'(obs_l[i]) : 32'hxxxxxxxx;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_since = 0;
    for (int k = 0; k < NT; k++) m_hist[k] = '0;
    m_valid = 0; m_last = 0; m_tready = 0; m_yvalid = 0; m_ylast = 0;
    exp_acc = '0; exp_y = '0; mac_acc = '0; mac_y = '0;
  endtask

  task automatic obs_clear();
    obs_y.delete(); obs_l.delete(); exp_ycnt = 0;
  endtask

  // Called at a negedge; checks this cycle's outputs, applies inputs for the
  // coming edge, advances the model over that edge and returns at the next negedge.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit e, input bit c);
    logic [31:0] ex_x;
    bit hs;
    ss_tvalid = v; ss_tdata = d; ss_tlast = l; en = e; clr = c;
    ex_x = m_valid ? m_hist[m_phase] : 32'd0;
    chk("X", X, ex_x);
    chk("ss_tready", 32'(ss_tready), 32'(m_tready));
    chk("y_valid", 32'(y_valid), 32'(m_yvalid));
    chk("y_last", 32'(y_last), 32'(m_ylast));
    if (m_since == 0) begin
      chk("tap_EN", 32'(tap_EN), 32'd0);
      chk("tap_A", 32'(tap_A), 32'(TAP_BASE));
    end else begin
      chk("tap_EN", 32'(tap_EN), 32'd1);
      chk("tap_A", 32'(tap_A), 32'(TAP_BASE) + 32'(4 * ((m_phase + 1) % NT)));
    end
    if (m_since >= 2) chk("tap", tap, 32'(m_phase + 1));
    // MAC model on the operands actually presented
    if (m_phase == 0) begin mac_y = mac_acc; mac_acc = '0; end
    mac_acc = mac_acc + X * tap;
    exp_acc = exp_acc + ex_x * 32'(m_phase + 1);
    if (y_valid === 1'b1) begin obs_y.push_back(mac_y); obs_l.push_back(y_last); end
    if (m_yvalid) begin exp_ycnt++; chk("Y", mac_y, exp_y); end
    hs = v && m_tready;
    @(posedge CLK);
    if (m_phase == NT - 1) begin
      m_yvalid = m_valid; m_ylast = m_last;
      exp_y = exp_acc; exp_acc = '0;
      if (hs) begin
        for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
      end
      m_valid = hs; m_last = hs && l;
    end else begin
      m_yvalid = 0; m_ylast = 0;
    end
    if (c) begin
      for (int k = 1; k < NT; k++) m_hist[k] = '0;
      if (!hs) m_hist[0] = '0;
    end
    m_tready = e && (m_phase == NT - 2);
    m_phase  = (m_phase + 1) % NT;
    m_since++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
  endtask

  // Hold the sample valid until it is taken; bounded to two frames.
  task automatic send(input logic [31:0] d, input bit l);
    bit done;
    bit hs;
    done = 0;
    for (int i = 0; i < 2 * NT + 2 && !done; i++) begin
      hs = m_tready;
      step(1'b1, d, l, 1'b1, 1'b0);
      done = hs;
    end
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    Resetn = 1'b0; ss_tvalid = 1'b0; en = 1'b0; clr = 1'b0;
    #1;
    chk("rst_ss_tready", 32'(ss_tready), 32'd0);
    chk("rst_tap_EN", 32'(tap_EN), 32'd0);
    chk("rst_tap_A", 32'(tap_A), 32'(TAP_BASE));
    chk("rst_X", X, 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y_last", 32'(y_last), 32'd0);
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    Resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_rdy;
    model_reset();
    obs_clear();
    @(negedge CLK);
    do_reset();

    // 1. Idle after reset: nothing valid, tap addresses sweep
    idle(2 * NT);
    chk("hold_no_y", 32'(obs_y.size()), 32'd0);

    // 2. Impulse response
    obs_clear();
    send(32'd1, 1'b0);
    repeat (NT) send(32'd0, 1'b0);
    idle(2 * NT);
    chk("imp_count", 32'(obs_y.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("imp_y%0d", i), get_y(i), (i < NT) ? 32'(i + 1) : 32'd0);

    // 3. Step of 2s, tlast on the 12th
    obs_clear();
    repeat (NT) send(32'd2, 1'b0);
    send(32'd2, 1'b1);
    idle(2 * NT);
    chk("step_count", 32'(obs_y.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("step_y%0d", i), get_y(i), (i < NT) ? 32'((i + 1) * (i + 2)) : 32'd132);
      chk($sformatf("step_last%0d", i), get_l(i), (i == 11) ? 32'd1 : 32'd0);
    end

    // 4. Two empty frames between samples
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    obs_clear();
    send(32'd5, 1'b0);
    idle(2 * NT);
    send(32'd7, 1'b0);
    idle(2 * NT);
    chk("gap_count", 32'(obs_y.size()), 32'd2);
    chk("gap_y0", get_y(0), 32'd5);
    chk("gap_y1", get_y(1), 32'd17);

    // 5. clr during an in-flight frame
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    obs_clear();
    repeat (3) send(32'd3, 1'b0);
    for (int i = 0; i < NT && m_phase != 4; i++) idle(1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    send(32'd1, 1'b0);
    idle(2 * NT);
    chk("clr_count", 32'(obs_y.size()), 32'd4);
    chk("clr_y0", get_y(0), 32'd3);
    chk("clr_y1", get_y(1), 32'd9);
    chk("clr_y2", get_y(2), 32'd18);
    chk("clr_y3", get_y(3), 32'd1);

    // 6. Reset at phase 6 of a valid frame
    obs_clear();
    send($urandom_range(1, 1000), 1'b1);
    for (int i = 0; i < NT && m_phase != 6; i++) idle(1);
    do_reset();
    first_rdy = -1;
    for (int i = 0; i < NT + 1; i++) begin
      if (ss_tready === 1'b1 && first_rdy < 0) first_rdy = i;
      idle(1);
    end
    chk("rdy_after_rst", 32'(first_rdy), 32'd10);
    idle(2 * NT);
    chk("rst_no_y", 32'(obs_y.size()), 32'd0);

    // 7. Randomised traffic with en drops and occasional clr
    obs_clear();
    repeat (600)
      step(1'($urandom % 2), $urandom, 1'($urandom % 8 == 0), 1'($urandom % 10 != 0), 1'($urandom % 50 == 0));
    idle(2 * NT);
    chk("rand_y_count", 32'(obs_y.size()), 32'(exp_ycnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
